// File: rtl/pc_gen_unit.sv
// Program-counter generator for the RV32I fetch path.
// Selects sequential, branch/JAL, JALR or trap next-PC, with a fetch handshake and misaligned-target fault.
//
// state | meaning
// BOOT  | first cycle after reset, no fetch request yet
// RUN   | issuing fetch requests, accepting redirects
// FAULT | misaligned target rejected, waiting for a trap redirect
module pc_gen_unit #(
  parameter int unsigned       XLEN        = 32,
  parameter logic [XLEN-1:0]   RESET_VEC   = '0,
  parameter int unsigned       PC_INC      = 4,
  parameter bit                ALIGN_CHECK = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic [1:0]      pc_src_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] pc_imm_i,
  input  logic [XLEN-1:0] alu_out_i,
  input  logic [XLEN-1:0] trap_vec_i,
  input  logic            fetch_ready_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus_inc_o,
  output logic            pc_valid_o,
  output logic            flush_o,
  output logic            misalign_o,
  output logic [XLEN-1:0] misalign_addr_o,
  output logic [1:0]      state_o
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_FAULT = 2'd2
  } state_e;

  localparam logic [XLEN-1:0] INC       = XLEN'(PC_INC);
  localparam logic [XLEN-1:0] TRAP_MASK = ~XLEN'(3);
  localparam logic [XLEN-1:0] JALR_MASK = ~XLEN'(1);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            flush_q, flush_d;
  logic            misalign_q, misalign_d;
  logic [XLEN-1:0] mis_addr_q, mis_addr_d;

  logic [XLEN-1:0] trap_tgt;
  logic [XLEN-1:0] jump_tgt;
  logic            tgt_misaligned;
  logic            fire;
  logic            trap_req;
  logic            jump_req;

  assign trap_tgt       = trap_vec_i & TRAP_MASK;
  assign jump_tgt       = (pc_src_i == 2'd1) ? pc_imm_i : (alu_out_i & JALR_MASK);
  assign tgt_misaligned = ALIGN_CHECK && (jump_tgt[1:0] != 2'b00);
  assign fire           = pc_valid_o & fetch_ready_i;
  assign trap_req       = redirect_valid_i && (pc_src_i == 2'd3);
  assign jump_req       = redirect_valid_i && ((pc_src_i == 2'd1) || (pc_src_i == 2'd2));

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_VEC;
      flush_q    <= 1'b0;
      misalign_q <= 1'b0;
      mis_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      flush_q    <= flush_d;
      misalign_q <= misalign_d;
      mis_addr_q <= mis_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    flush_d    = 1'b0;
    misalign_d = 1'b0;
    mis_addr_d = mis_addr_q;
    unique case (state_q)
      S_BOOT: state_d = S_RUN;
      S_RUN: begin
        // A redirect always wins over a same-cycle sequential advance.
        if (trap_req) begin
          pc_d    = trap_tgt;
          flush_d = 1'b1;
        end else if (jump_req) begin
          flush_d = 1'b1;
          if (tgt_misaligned) begin
            misalign_d = 1'b1;
            mis_addr_d = jump_tgt;
            state_d    = S_FAULT;
          end else begin
            pc_d = jump_tgt;
          end
        end else if (fire) begin
          pc_d = pc_q + INC;
        end
      end
      S_FAULT: begin
        if (trap_req) begin
          pc_d    = trap_tgt;
          flush_d = 1'b1;
          state_d = S_RUN;
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  assign pc_o            = pc_q;
  assign pc_plus_inc_o   = pc_q + INC;
  assign pc_valid_o      = (state_q == S_RUN);
  assign flush_o         = flush_q;
  assign misalign_o      = misalign_q;
  assign misalign_addr_o = mis_addr_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Directed bench for pc_gen_unit: boot, stall, redirects, misalign fault, wrap and reset-in-fault.
module tb_pc_gen_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  pc_src;
  logic        redirect_valid;
  logic [31:0] pc_imm;
  logic [31:0] alu_out;
  logic [31:0] trap_vec;
  logic        fetch_ready;
  logic [31:0] pc;
  logic [31:0] pc_plus_inc;
  logic        pc_valid;
  logic        flush;
  logic        misalign;
  logic [31:0] misalign_addr;
  logic [1:0]  state;

  int compares = 0;
  int errs     = 0;

  always #5 clk = ~clk;

  pc_gen_unit dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n),
    .pc_src_i         (pc_src),
    .redirect_valid_i (redirect_valid),
    .pc_imm_i         (pc_imm),
    .alu_out_i        (alu_out),
    .trap_vec_i       (trap_vec),
    .fetch_ready_i    (fetch_ready),
    .pc_o             (pc),
    .pc_plus_inc_o    (pc_plus_inc),
    .pc_valid_o       (pc_valid),
    .flush_o          (flush),
    .misalign_o       (misalign),
    .misalign_addr_o  (misalign_addr),
    .state_o          (state)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compares++;
    assert (obs === exp)
      else begin
        errs++;
        $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic e_valid,
                         input logic e_flush, input logic e_mis, input logic [1:0] e_state);
    chk({tag, ".pc"},    pc,                e_pc);
    chk({tag, ".valid"}, {31'b0, pc_valid}, {31'b0, e_valid});
    chk({tag, ".flush"}, {31'b0, flush},    {31'b0, e_flush});
    chk({tag, ".mis"},   {31'b0, misalign}, {31'b0, e_mis});
    chk({tag, ".state"}, {30'b0, state},    {30'b0, e_state});
  endtask

  initial begin
    rst_n          = 1'b0;
    pc_src         = 2'd0;
    redirect_valid = 1'b0;
    pc_imm         = '0;
    alu_out        = '0;
    trap_vec       = '0;
    fetch_ready    = 1'b1;
    step();
    step();
    chk_all("reset", 32'h0, 1'b0, 1'b0, 1'b0, 2'd0);
    chk("reset.maddr", misalign_addr, 32'h0);

    // Reset released: still BOOT until the next edge.
    rst_n = 1'b1;
    #1;
    chk_all("boot", 32'h0, 1'b0, 1'b0, 1'b0, 2'd0);
    step();
    chk_all("run0", 32'h0, 1'b1, 1'b0, 1'b0, 2'd1);
    step();
    chk("seq4", pc, 32'h4);
    step();
    chk("seq8", pc, 32'h8);
    step();
    step();
    chk("seq10", pc, 32'h10);
    chk("plus_inc", pc_plus_inc, 32'h14);

    // Stall
    fetch_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all("stall", 32'h10, 1'b1, 1'b0, 1'b0, 2'd1);
    end
    fetch_ready = 1'b1;
    step();
    chk("release", pc, 32'h14);

    // JALR, bit 0 cleared, simultaneous fire discarded
    pc_src = 2'd2; alu_out = 32'h101; redirect_valid = 1'b1;
    step();
    chk_all("jalr", 32'h100, 1'b1, 1'b1, 1'b0, 2'd1);
    redirect_valid = 1'b0;
    step();
    chk_all("jalr_next", 32'h104, 1'b1, 1'b0, 1'b0, 2'd1);

    // Misaligned branch target
    pc_src = 2'd1; pc_imm = 32'h202; redirect_valid = 1'b1;
    step();
    chk_all("mis", 32'h104, 1'b0, 1'b1, 1'b1, 2'd2);
    chk("mis.maddr", misalign_addr, 32'h202);
    step();
    chk_all("fault_ign", 32'h104, 1'b0, 1'b0, 1'b0, 2'd2);
    chk("fault.maddr", misalign_addr, 32'h202);
    pc_src = 2'd3; trap_vec = 32'h803;
    step();
    chk_all("trap_exit", 32'h800, 1'b1, 1'b1, 1'b0, 2'd1);
    redirect_valid = 1'b0;
    step();
    chk_all("trap_next", 32'h804, 1'b1, 1'b0, 1'b0, 2'd1);

    // Aligned branch, then src 0 with valid set acts as no redirect
    pc_src = 2'd1; pc_imm = 32'h400; redirect_valid = 1'b1;
    step();
    chk_all("br", 32'h400, 1'b1, 1'b1, 1'b0, 2'd1);
    pc_src = 2'd0;
    step();
    chk_all("src0", 32'h404, 1'b1, 1'b0, 1'b0, 2'd1);

    // Trap beats fire, then wrap
    pc_src = 2'd3; trap_vec = 32'hFFFF_FFFF;
    step();
    chk_all("trap_top", 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0, 2'd1);
    redirect_valid = 1'b0;
    step();
    chk_all("wrap", 32'h0, 1'b1, 1'b0, 1'b0, 2'd1);

    // Misaligned JALR into FAULT, then reset with fire pending
    pc_src = 2'd2; alu_out = 32'h103; redirect_valid = 1'b1;
    step();
    chk_all("mis2", 32'h0, 1'b0, 1'b1, 1'b1, 2'd2);
    chk("mis2.maddr", misalign_addr, 32'h102);
    redirect_valid = 1'b0; fetch_ready = 1'b1; rst_n = 1'b0;
    step();
    chk_all("rst_fault", 32'h0, 1'b0, 1'b0, 1'b0, 2'd0);
    chk("rst_fault.maddr", misalign_addr, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errs);
    $finish;
  end

endmodule
